// File: rtl/viterbi_traceback.sv
// Traceback unit for the K=3 (4-state) Viterbi decoder: snapshots the decision window and walks the trellis newest-to-oldest.
// Latency: start accepted at edge N -> first out_valid after edge N+DEPTH; window then streams DEPTH bits oldest-first.
// Backpressure: out_ready low holds out_bit/out_last and the emit index; start is ignored while busy.
// Ports: clk/rst_n; start, best_state, dec00_i..dec11_i (snapshot inputs); out_ready;
//        busy, out_valid/out_bit/out_last (output stream), done (pulse), end_state (oldest-step state).
module viterbi_traceback #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       best_state,
  input  logic [DEPTH-1:0] dec00_i,
  input  logic [DEPTH-1:0] dec01_i,
  input  logic [DEPTH-1:0] dec10_i,
  input  logic [DEPTH-1:0] dec11_i,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  output logic             done,
  output logic [1:0]       end_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACE = 2'd1, EMIT = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  state_t                  state;
  logic [3:0][DEPTH-1:0]   snap;     // snap[s] = decision vector of state s
  logic [DEPTH-1:0]        bits;     // decoded bits, bit 0 oldest
  logic [1:0]              cur;
  logic [CNT_W-1:0]        idx;
  logic [CNT_W-1:0]        eidx;

  logic [DEPTH-1:0]        dec_cur;
  logic [DEPTH-1:0]        dec_sh;
  logic [DEPTH-1:0]        idx_oh;
  logic [DEPTH-1:0]        buf_sh;
  logic                    d_bit;

  // Shifts instead of variable bit-selects keep counter width independent of DEPTH.
  assign dec_cur  = snap[cur];
  assign dec_sh   = dec_cur >> idx;
  assign d_bit    = dec_sh[0];
  assign idx_oh   = {{(DEPTH-1){1'b0}}, 1'b1} << idx;
  assign buf_sh   = bits >> eidx;
  assign out_bit  = buf_sh[0];
  assign out_last = out_valid & (eidx == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      snap      <= '0;
      bits      <= '0;
      cur       <= 2'b00;
      idx       <= '0;
      eidx      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      end_state <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= {dec11_i, dec10_i, dec01_i, dec00_i};
            cur   <= best_state;
            idx   <= LAST;
            busy  <= 1'b1;
            state <= TRACE;
          end
        end
        TRACE: begin
          // Decoded bit is the newest input held in s[1]; predecessor is {s[0], decision}.
          bits <= cur[1] ? (bits | idx_oh) : (bits & ~idx_oh);
          cur  <= {cur[0], d_bit};
          idx  <= idx - CNT_W'(1);
          if (idx == '0) begin
            end_state <= {cur[0], d_bit};
            eidx      <= '0;
            out_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (eidx == LAST) begin
              // Clearing eidx drops out_last and parks out_bit on the oldest bit.
              eidx      <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              eidx <= eidx + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
module tb_viterbi_traceback;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] best_state;
  logic [7:0] dec00_i, dec01_i, dec10_i, dec11_i;
  logic       out_ready;
  logic       busy, out_valid, out_bit, out_last, done;
  logic [1:0] end_state;

  int vectors = 0;
  int miscompares = 0;
  int busy_falls = 0;
  logic busy_prev = 1'b0;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] exp_end[$];

  viterbi_traceback #(.DEPTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .best_state(best_state),
    .dec00_i(dec00_i), .dec01_i(dec01_i), .dec10_i(dec10_i), .dec11_i(dec11_i),
    .out_ready(out_ready), .busy(busy), .out_valid(out_valid), .out_bit(out_bit),
    .out_last(out_last), .done(done), .end_state(end_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every handshake pops one expected bit.
  always @(negedge clk) begin
    busy_prev <= busy;
    if (busy_prev && !busy) busy_falls++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bit", 8'(out_valid), 8'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_bit", 8'(out_bit), 8'(e.b));
        chk("out_last", 8'(out_last), 8'(e.last));
      end
    end
  end

  // Encoder model: x = {u, u[-1], u[-2]}; path state at step t is {u[t], u[t-1]}
  // and its decision is u[t-2]. Off-path decisions are random or zero.
  task automatic load(input logic [7:0] u, input logic [1:0] h, input bit rnd);
    logic [3:0][7:0] d;
    logic [9:0]      x;
    logic [1:0]      s;
    x = {u, h};
    for (int k = 0; k < 4; k++) d[k] = rnd ? 8'($urandom) : 8'h00;
    for (int t = 0; t < 8; t++) begin
      s = {x[t+2], x[t+1]};
      d[s][t] = x[t];
    end
    dec00_i = d[0]; dec01_i = d[1]; dec10_i = d[2]; dec11_i = d[3];
    best_state = {u[7], u[6]};
    for (int t = 0; t < 8; t++) exp_q.push_back('{b: u[t], last: (t == 7)});
    // The walk ends at the state before the window: {u[-1], u[-2]}.
    exp_end.push_back(h);
  endtask

  task automatic scramble();
    dec00_i = 8'($urandom); dec01_i = 8'($urandom);
    dec10_i = 8'($urandom); dec11_i = 8'($urandom);
    best_state = 2'($urandom);
  endtask

  task automatic accept(input bit keep);
    start = 1'b1;
    @(posedge clk); #1;
    if (!keep) start = 1'b0;
    chk("busy_after_accept", 8'(busy), 8'd1);
    scramble();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    logic [1:0] ee;
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 8'(done), 8'd1);
    ee = (exp_end.size() != 0) ? exp_end.pop_front() : 2'bxx;
    chk({tag, "_end_state"}, 8'(end_state), 8'(ee));
    chk({tag, "_bits_left"}, 8'(exp_q.size()), 8'd0);
    chk({tag, "_busy_low"}, 8'(busy), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    rst_n = 1'b0; start = 1'b0; best_state = 2'b00; out_ready = 1'b1;
    dec00_i = 8'h00; dec01_i = 8'h00; dec10_i = 8'h00; dec11_i = 8'h00;
    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_out_valid", 8'(out_valid), 8'd0);
    chk("rst_out_bit", 8'(out_bit), 8'd0);
    chk("rst_out_last", 8'(out_last), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_end_state", 8'(end_state), 8'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: all-zero decisions, best state 00.
    load(8'h00, 2'b00, 1'b0);
    accept(1'b0);
    wait_done("t1");
    @(negedge clk);
    chk("t1_done_one_cycle", 8'(done), 8'd0);

    // 2: inputs 1,0,1,1,0,0,1,0 oldest first (bit t = u[t]), zero history, plus latency check.
    @(posedge clk); #1;
    load(8'h4D, 2'b00, 1'b1);
    accept(1'b0);
    repeat (7) @(posedge clk);
    #1 chk("t2_valid_early", 8'(out_valid), 8'd0);
    @(posedge clk);
    #1 chk("t2_valid_on_time", 8'(out_valid), 8'd1);
    wait_done("t2");

    // 3: same window, stall at eidx=2 for three cycles.
    @(posedge clk); #1;
    load(8'h4D, 2'b00, 1'b1);
    accept(1'b0);
    repeat (8) @(posedge clk);
    #1 chk("t3_valid", 8'(out_valid), 8'd1);
    @(posedge clk); @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t3_stall_bit", 8'(out_bit), 8'd1);
      chk("t3_stall_valid", 8'(out_valid), 8'd1);
      chk("t3_stall_last", 8'(out_last), 8'd0);
    end
    out_ready = 1'b1;
    wait_done("t3");

    // 4: start pulses during TRACE and EMIT are ignored; nonzero history.
    @(posedge clk); #1;
    f0 = busy_falls;
    load(8'hB6, 2'b10, 1'b1);
    accept(1'b0);
    @(posedge clk); @(posedge clk);
    #1 start = 1'b1; scramble();
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 start = 1'b1; scramble();
    chk("t4_in_emit", 8'(out_valid), 8'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("t4");
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_restart", 8'(busy), 8'd0);
    chk("t4_busy_falls", 8'(busy_falls - f0), 8'd1);

    // 5: reset mid-TRACE at idx=4, then a fresh window.
    load(8'h5A, 2'b11, 1'b1);
    accept(1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_busy", 8'(busy), 8'd0);
    chk("t5_valid", 8'(out_valid), 8'd0);
    chk("t5_bit", 8'(out_bit), 8'd0);
    chk("t5_last", 8'(out_last), 8'd0);
    chk("t5_done", 8'(done), 8'd0);
    chk("t5_end_state", 8'(end_state), 8'd0);
    exp_q.delete();
    exp_end.delete();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    load(8'hC3, 2'b01, 1'b1);
    accept(1'b0);
    wait_done("t5");

    // 6: start held high, three back-to-back windows re-accepted in the done cycle.
    @(posedge clk); #1;
    load(8'h96, 2'b10, 1'b1);
    accept(1'b1);
    wait_done("t6a");
    load(8'h2F, 2'b01, 1'b1);
    accept(1'b1);
    wait_done("t6b");
    load(8'hE1, 2'b11, 1'b1);
    accept(1'b0);
    wait_done("t6c");

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
